// File: rtl/gnss_code_pkg.sv
// Shared types and helpers for the multi-channel GNSS code generator.
//   chan_state_e   - per-channel FSM state (IDLE / ARMED / RUN)
//   cfg_sel_e      - which init register a config write targets
//   masked_parity  - XOR reduction of (register & taps), the LFSR feedback bit
package gnss_code_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2
  } chan_state_e;

  typedef enum logic [1:0] {
    SEL_PRI_A = 2'd0,
    SEL_PRI_B = 2'd1,
    SEL_SEC_A = 2'd2,
    SEL_SEC_B = 2'd3
  } cfg_sel_e;

  // Widest LFSR the helper accepts; narrower registers are zero-extended.
  localparam int unsigned MAX_LFSR_W = 32;

  function automatic logic masked_parity(input logic [MAX_LFSR_W-1:0] r,
                                         input logic [MAX_LFSR_W-1:0] taps);
    return ^(r & taps);
  endfunction

endpackage

// File: rtl/gnss_code_gen_mc_chan.sv
// One code channel: FSM, init registers, primary/secondary Fibonacci LFSR
// pairs, chip and overlay counters, and (optionally) chip slip.
// Optional feature macro: GNSS_CODE_SLIP_EN adds slip_req / slip_dir.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   cfg_we/sel/data       init register write (already gated by top)
//   start, stop           this channel's arm / force-idle requests
//   chip_stb              shared registered NCO carry
//   slip_req, slip_dir    (macro only) slip request pulse and direction
//   idle                  channel in IDLE (drives cfg_ready at top)
//   code/pri/sec          chip outputs; epoch_pri/epoch_sec wrap pulses
//   running               channel in RUN
module gnss_code_chan
  import gnss_code_pkg::*;
#(
  parameter int               PRI_W      = 13,
  parameter int               PRI_LEN    = 10230,
  parameter logic [PRI_W-1:0] PRI_TAPS_A = 13'h001B,
  parameter logic [PRI_W-1:0] PRI_TAPS_B = 13'h0C01,
  parameter int               SEC_W      = 10,
  parameter int               SEC_LEN    = 1800,
  parameter logic [SEC_W-1:0] SEC_TAPS_A = 10'h027,
  parameter logic [SEC_W-1:0] SEC_TAPS_B = 10'h00F,
  parameter int               DATA_W     = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_sel,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              start,
  input  logic              stop,
  input  logic              chip_stb,
`ifdef GNSS_CODE_SLIP_EN
  input  logic              slip_req,
  input  logic              slip_dir,
`endif
  output logic              idle,
  output logic              code,
  output logic              pri,
  output logic              sec,
  output logic              epoch_pri,
  output logic              epoch_sec,
  output logic              running
);

  localparam logic [PRI_W-1:0] PRI_LAST = PRI_W'(PRI_LEN - 1);
  localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_LEN - 1);

  chan_state_e      state_q, state_d;
  logic [PRI_W-1:0] init_pa_q, init_pa_d, init_pb_q, init_pb_d;
  logic [PRI_W-1:0] pa_q, pa_d, pb_q, pb_d, chip_cnt_q, chip_cnt_d;
  logic [SEC_W-1:0] init_sa_q, init_sa_d, init_sb_q, init_sb_d;
  logic [SEC_W-1:0] sa_q, sa_d, sb_q, sb_d, sec_cnt_q, sec_cnt_d;
  logic             epoch_pri_q, epoch_pri_d, epoch_sec_q, epoch_sec_d;
  logic [1:0]       steps;
  logic             wrapped;
`ifdef GNSS_CODE_SLIP_EN
  logic             slip_pend_q, slip_pend_d, slip_dir_q, slip_dir_d;
`endif

  function automatic logic [PRI_W-1:0] pri_step(input logic [PRI_W-1:0] r,
                                                input logic [PRI_W-1:0] taps);
    return {masked_parity(MAX_LFSR_W'(r), MAX_LFSR_W'(taps)), r[PRI_W-1:1]};
  endfunction

  function automatic logic [SEC_W-1:0] sec_step(input logic [SEC_W-1:0] r,
                                                input logic [SEC_W-1:0] taps);
    return {masked_parity(MAX_LFSR_W'(r), MAX_LFSR_W'(taps)), r[SEC_W-1:1]};
  endfunction

  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    init_pa_d   = init_pa_q;
    init_pb_d   = init_pb_q;
    init_sa_d   = init_sa_q;
    init_sb_d   = init_sb_q;
    pa_d        = pa_q;
    pb_d        = pb_q;
    sa_d        = sa_q;
    sb_d        = sb_q;
    chip_cnt_d  = chip_cnt_q;
    sec_cnt_d   = sec_cnt_q;
    epoch_pri_d = 1'b0;
    epoch_sec_d = 1'b0;
    steps       = 2'd0;
    wrapped     = 1'b0;
`ifdef GNSS_CODE_SLIP_EN
    slip_pend_d = slip_pend_q;
    slip_dir_d  = slip_dir_q;
`endif

    // Stop beats start; start (re-)arms from any state; otherwise the strobe
    // either releases ARMED into RUN (chip 0 held a full period) or advances.
    if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      state_d    = ARMED;
      pa_d       = init_pa_q;
      pb_d       = init_pb_q;
      sa_d       = init_sa_q;
      sb_d       = init_sb_q;
      chip_cnt_d = '0;
      sec_cnt_d  = '0;
    end else if (chip_stb) begin
      if (state_q == ARMED) begin
        state_d = RUN;
      end else if (state_q == RUN) begin
`ifdef GNSS_CODE_SLIP_EN
        steps = slip_pend_q ? (slip_dir_q ? 2'd2 : 2'd0) : 2'd1;
`else
        steps = 2'd1;
`endif
      end
    end

    // Up to two single-chip steps; a wrap ends the advance for this strobe.
    for (int k = 0; k < 2; k++) begin
      if (k < int'(steps) && !wrapped) begin
        if (chip_cnt_d == PRI_LAST) begin
          wrapped     = 1'b1;
          pa_d        = init_pa_q;
          pb_d        = init_pb_q;
          chip_cnt_d  = '0;
          epoch_pri_d = 1'b1;
          if (sec_cnt_q == SEC_LAST) begin
            sa_d        = init_sa_q;
            sb_d        = init_sb_q;
            sec_cnt_d   = '0;
            epoch_sec_d = 1'b1;
          end else begin
            sa_d      = sec_step(sa_q, SEC_TAPS_A);
            sb_d      = sec_step(sb_q, SEC_TAPS_B);
            sec_cnt_d = sec_cnt_q + 1'b1;
          end
        end else begin
          pa_d       = pri_step(pa_d, PRI_TAPS_A);
          pb_d       = pri_step(pb_d, PRI_TAPS_B);
          chip_cnt_d = chip_cnt_d + 1'b1;
        end
      end
    end

`ifdef GNSS_CODE_SLIP_EN
    // A pending slip is consumed by the first strobe seen while in RUN.
    if (state_q == RUN && chip_stb) slip_pend_d = 1'b0;
    if (slip_req) begin
      slip_pend_d = 1'b1;
      slip_dir_d  = slip_dir;
    end
    if (stop) slip_pend_d = 1'b0;
`endif

    if (cfg_we) begin
      unique case (cfg_sel_e'(cfg_sel))
        SEL_PRI_A: init_pa_d = cfg_data[PRI_W-1:0];
        SEL_PRI_B: init_pb_d = cfg_data[PRI_W-1:0];
        SEL_SEC_A: init_sa_d = cfg_data[SEC_W-1:0];
        SEL_SEC_B: init_sb_d = cfg_data[SEC_W-1:0];
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      // NOTE: init registers are real configuration state and must come out of reset all-ones, so they are reset like any other flop.
      init_pa_q   <= '1;
      init_pb_q   <= '1;
      init_sa_q   <= '1;
      init_sb_q   <= '1;
      pa_q        <= '0;
      pb_q        <= '0;
      sa_q        <= '0;
      sb_q        <= '0;
      chip_cnt_q  <= '0;
      sec_cnt_q   <= '0;
      epoch_pri_q <= 1'b0;
      epoch_sec_q <= 1'b0;
`ifdef GNSS_CODE_SLIP_EN
      slip_pend_q <= 1'b0;
      slip_dir_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      init_pa_q   <= init_pa_d;
      init_pb_q   <= init_pb_d;
      init_sa_q   <= init_sa_d;
      init_sb_q   <= init_sb_d;
      pa_q        <= pa_d;
      pb_q        <= pb_d;
      sa_q        <= sa_d;
      sb_q        <= sb_d;
      chip_cnt_q  <= chip_cnt_d;
      sec_cnt_q   <= sec_cnt_d;
      epoch_pri_q <= epoch_pri_d;
      epoch_sec_q <= epoch_sec_d;
`ifdef GNSS_CODE_SLIP_EN
      slip_pend_q <= slip_pend_d;
      slip_dir_q  <= slip_dir_d;
`endif
    end
  end

  // Chips come straight from the shift-register LSBs; IDLE forces them low.
  assign idle      = (state_q == IDLE);
  assign running   = (state_q == RUN);
  assign pri       = !idle && (pa_q[0] ^ pb_q[0]);
  assign sec       = !idle && (sa_q[0] ^ sb_q[0]);
  assign code      = pri ^ sec;
  assign epoch_pri = epoch_pri_q;
  assign epoch_sec = epoch_sec_q;

endmodule

// File: rtl/gnss_code_gen_mc.sv
// Multi-channel pilot code generator: shared chip-rate NCO, config decode and
// cfg_ready mux, NCH instances of gnss_code_chan.
// Optional feature macro: GNSS_CODE_SLIP_EN adds slip_req[NCH] and slip_dir.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   cfg_valid/ready/ch/sel/data    init register write handshake
//   nco_fcw                        chip-rate frequency control word
//   ch_mask, start, stop           channel arm / force-idle controls
//   chip_stb                       registered NCO carry (one clk)
//   code_out, pri_out, sec_out     per-channel chips
//   epoch_pri, epoch_sec, running  per-channel status
module gnss_code_gen_mc
  import gnss_code_pkg::*;
#(
  parameter int               NCH        = 4,
  parameter int               PRI_W      = 13,
  parameter int               PRI_LEN    = 10230,
  parameter logic [PRI_W-1:0] PRI_TAPS_A = 13'h001B,
  parameter logic [PRI_W-1:0] PRI_TAPS_B = 13'h0C01,
  parameter int               SEC_W      = 10,
  parameter int               SEC_LEN    = 1800,
  parameter logic [SEC_W-1:0] SEC_TAPS_A = 10'h027,
  parameter logic [SEC_W-1:0] SEC_TAPS_B = 10'h00F,
  parameter int               NCO_W      = 24,
  localparam int              CHW        = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int              DW         = (PRI_W > SEC_W) ? PRI_W : SEC_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CHW-1:0]   cfg_ch,
  input  logic [1:0]       cfg_sel,
  input  logic [DW-1:0]    cfg_data,
  input  logic [NCO_W-1:0] nco_fcw,
  input  logic [NCH-1:0]   ch_mask,
  input  logic             start,
  input  logic             stop,
`ifdef GNSS_CODE_SLIP_EN
  input  logic [NCH-1:0]   slip_req,
  input  logic             slip_dir,
`endif
  output logic             chip_stb,
  output logic [NCH-1:0]   code_out,
  output logic [NCH-1:0]   pri_out,
  output logic [NCH-1:0]   sec_out,
  output logic [NCH-1:0]   epoch_pri,
  output logic [NCH-1:0]   epoch_sec,
  output logic [NCH-1:0]   running
);

  logic [NCO_W-1:0]   acc_q, acc_d;
  logic               chip_stb_q, chip_stb_d;
  logic [NCH-1:0]     ch_idle;
  logic [2**CHW-1:0]  idle_ext;

  always_comb {chip_stb_d, acc_d} = {1'b0, acc_q} + {1'b0, nco_fcw};

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q      <= '0;
      chip_stb_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      chip_stb_q <= chip_stb_d;
    end
  end

  assign chip_stb = chip_stb_q;

  // Unpopulated channel addresses read as ready so writes to them drain.
  always_comb begin
    idle_ext          = '1;
    idle_ext[NCH-1:0] = ch_idle;
    cfg_ready         = idle_ext[cfg_ch];
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    gnss_code_chan #(
      .PRI_W      (PRI_W),
      .PRI_LEN    (PRI_LEN),
      .PRI_TAPS_A (PRI_TAPS_A),
      .PRI_TAPS_B (PRI_TAPS_B),
      .SEC_W      (SEC_W),
      .SEC_LEN    (SEC_LEN),
      .SEC_TAPS_A (SEC_TAPS_A),
      .SEC_TAPS_B (SEC_TAPS_B),
      .DATA_W     (DW)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .cfg_we    (cfg_valid && cfg_ready && (cfg_ch == CHW'(i))),
      .cfg_sel   (cfg_sel),
      .cfg_data  (cfg_data),
      .start     (start && ch_mask[i]),
      .stop      (stop && ch_mask[i]),
      .chip_stb  (chip_stb_q),
`ifdef GNSS_CODE_SLIP_EN
      .slip_req  (slip_req[i]),
      .slip_dir  (slip_dir),
`endif
      .idle      (ch_idle[i]),
      .code      (code_out[i]),
      .pri       (pri_out[i]),
      .sec       (sec_out[i]),
      .epoch_pri (epoch_pri[i]),
      .epoch_sec (epoch_sec[i]),
      .running   (running[i])
    );
  end

endmodule
